// File: rtl/panel_fill.sv
// Rectangle fill engine: walks a latched pixel rectangle (y inner, x outer) and issues one
// 24-bit colour write per pixel to the frame-buffer bus, waiting for each acknowledge.
module panel_fill #(
    parameter int SIZE = 1,
    localparam int XW = 5 + $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x0,
    input  logic [XW-1:0] cmd_x1,
    input  logic [4:0]    cmd_y0,
    input  logic [4:0]    cmd_y1,
    input  logic [23:0]   cmd_rgb,
    output logic          fill_done,
    output logic [3:0]    ctrl_wr,
    output logic          ctrl_rd,
    output logic [15:0]   ctrl_addr,
    output logic [31:0]   ctrl_wdat,
    input  logic          ctrl_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [4:0]    Y_ONE = 5'd1;

    state_t        state, state_nxt;
    logic [XW-1:0] x1_q;
    logic [4:0]    y0_q, y1_q;
    logic [23:0]   rgb_q;
    logic [XW-1:0] cur_x;
    logic [4:0]    cur_y;
    logic          accept;
    logic          empty_cmd;
    logic          last_px;
    logic          ack;
    logic [XW+6:0] addr_raw;

    assign accept    = cmd_valid && (state == IDLE);
    assign empty_cmd = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1);
    // Termination is decided by equality before any increment, so the counters never wrap.
    assign last_px   = (cur_x == x1_q) && (cur_y == y1_q);
    assign ack       = (state == WRITE) && ctrl_done;
    assign addr_raw  = {cur_x, cur_y, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cur_x <= '0;
            cur_y <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cur_x <= cmd_x0;
                cur_y <= cmd_y0;
            end else if (ack && !last_px) begin
                if (cur_y != y1_q) begin
                    cur_y <= cur_y + Y_ONE;
                end else begin
                    cur_y <= y0_q;
                    cur_x <= cur_x + X_ONE;
                end
            end
        end
    end

    // Command bounds and colour are plain data: only ever read while a fill is active.
    always_ff @(posedge clk) begin
        if (accept) begin
            x1_q  <= cmd_x1;
            y0_q  <= cmd_y0;
            y1_q  <= cmd_y1;
            rgb_q <= cmd_rgb;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = empty_cmd ? FINISH : WRITE;
            end
            WRITE: begin
                if (ctrl_done && last_px) state_nxt = FINISH;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        fill_done = 1'b0;
        ctrl_wr   = 4'b0000;
        ctrl_addr = 16'h0000;
        ctrl_wdat = 32'h0000_0000;
        unique case (state)
            IDLE:   cmd_ready = 1'b1;
            WRITE: begin
                ctrl_wr   = 4'b0111;
                ctrl_addr = 16'(addr_raw);
                ctrl_wdat = {8'h00, rgb_q};
            end
            FINISH: fill_done = 1'b1;
            default: ;
        endcase
    end

    assign ctrl_rd = 1'b0;

endmodule

// File: tb/tb_panel_fill.sv
// Directed bench for panel_fill: SIZE=1 and SIZE=2 instances driven and sampled on the falling edge.
module tb_panel_fill;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        c1_valid, c1_ready, d1_fd, d1_rd, d1_done;
    logic [4:0]  c1_x0, c1_x1, c1_y0, c1_y1;
    logic [23:0] c1_rgb;
    logic [3:0]  d1_wr;
    logic [15:0] d1_addr;
    logic [31:0] d1_wdat;

    logic        c2_valid, c2_ready, d2_fd, d2_rd, d2_done;
    logic [5:0]  c2_x0, c2_x1;
    logic [4:0]  c2_y0, c2_y1;
    logic [23:0] c2_rgb;
    logic [3:0]  d2_wr;
    logic [15:0] d2_addr;
    logic [31:0] d2_wdat;

    int errors = 0;
    int checks = 0;

    panel_fill #(.SIZE(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
        .cmd_x0(c1_x0), .cmd_x1(c1_x1), .cmd_y0(c1_y0), .cmd_y1(c1_y1), .cmd_rgb(c1_rgb),
        .fill_done(d1_fd), .ctrl_wr(d1_wr), .ctrl_rd(d1_rd), .ctrl_addr(d1_addr),
        .ctrl_wdat(d1_wdat), .ctrl_done(d1_done)
    );

    panel_fill #(.SIZE(2)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_x0(c2_x0), .cmd_x1(c2_x1), .cmd_y0(c2_y0), .cmd_y1(c2_y1), .cmd_rgb(c2_rgb),
        .fill_done(d2_fd), .ctrl_wr(d2_wr), .ctrl_rd(d2_rd), .ctrl_addr(d2_addr),
        .ctrl_wdat(d2_wdat), .ctrl_done(d2_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_cmd(input int sel, input logic v, input int x0, input int x1,
                             input int y0, input int y1, input logic [23:0] rgb);
        if (sel == 1) begin
            c1_valid = v; c1_x0 = x0[4:0]; c1_x1 = x1[4:0];
            c1_y0 = y0[4:0]; c1_y1 = y1[4:0]; c1_rgb = rgb;
        end else begin
            c2_valid = v; c2_x0 = x0[5:0]; c2_x1 = x1[5:0];
            c2_y0 = y0[4:0]; c2_y1 = y1[4:0]; c2_rgb = rgb;
        end
    endtask

    task automatic set_done(input int sel, input logic v);
        if (sel == 1) d1_done = v;
        else d2_done = v;
    endtask

    task automatic sample(input int sel, output logic [3:0] wr, output logic [15:0] a,
                          output logic [31:0] wd, output logic fd, output logic rdy);
        if (sel == 1) begin
            wr = d1_wr; a = d1_addr; wd = d1_wdat; fd = d1_fd; rdy = c1_ready;
        end else begin
            wr = d2_wr; a = d2_addr; wd = d2_wdat; fd = d2_fd; rdy = c2_ready;
        end
    endtask

    // maxd < 0: standard driver (ack on the second cycle of every write); else random 0..maxd wait.
    task automatic run_fill(input int sel, input int x0, input int x1, input int y0, input int y1,
                            input logic [23:0] rgb, input int maxd, input int abort_after,
                            output int nwr, output int span,
                            output logic [15:0] first_a, output logic [15:0] last_a);
        int total, ex, ey, cnt, dly, last_ack, done_cyc, first_wr;
        logic [3:0]  wr;
        logic [15:0] a;
        logic [31:0] wd;
        logic        fd, rdy;
        total    = (x0 > x1 || y0 > y1) ? 0 : (x1 - x0 + 1) * (y1 - y0 + 1);
        ex = x0; ey = y0; cnt = 0; nwr = 0; last_ack = 0; done_cyc = -1; first_wr = -1;
        first_a = 16'h0; last_a = 16'h0; span = 0;
        dly = (maxd < 0) ? 1 : int'($urandom_range(0, maxd));
        fd = 1'b0;
        drive_cmd(sel, 1'b1, x0, x1, y0, y1, rgb);
        tick();
        drive_cmd(sel, 1'b0, 0, 0, 0, 0, 24'hFFFFFF);
        for (int cyc = 1; cyc <= 6000; cyc++) begin
            sample(sel, wr, a, wd, fd, rdy);
            if (fd) begin
                done_cyc = cyc;
                chk("done_latency", cyc, (total == 0) ? 1 : last_ack + 1);
                chk("write_count", nwr, total);
                chk("ready_in_finish", {31'd0, rdy}, 0);
                chk("wr_in_finish", {28'd0, wr}, 0);
                drive_cmd(sel, 1'b0, 0, 0, 0, 0, 24'hFFFFFF);
                set_done(sel, 1'b0);
                tick();
                sample(sel, wr, a, wd, fd, rdy);
                chk("ready_after_finish", {31'd0, rdy}, 1);
                chk("single_done_pulse", {31'd0, fd}, 0);
                break;
            end
            chk("write_no_gap", {28'd0, wr}, 4'b0111);
            chk("extra_write", (nwr < total) ? 1 : 0, 1);
            chk("addr", {16'd0, a}, (ex << 7) | (ey << 2));
            chk("wdat", wd, {8'h00, rgb});
            if (first_wr < 0) first_wr = cyc;
            if (cnt == dly) begin
                set_done(sel, 1'b1);
                nwr++;
                last_ack = cyc;
                if (nwr == 1) first_a = a;
                last_a = a;
                if (ey < y1) ey++;
                else begin ey = y0; ex++; end
                cnt = 0;
                dly = (maxd < 0) ? 1 : int'($urandom_range(0, maxd));
            end else begin
                set_done(sel, 1'b0);
                cnt++;
            end
            drive_cmd(sel, (cyc % 2) == 1, 0, 0, 0, 0, 24'hFFFFFF);
            if (abort_after > 0 && nwr == abort_after) begin
                tick();
                set_done(sel, 1'b0);
                drive_cmd(sel, 1'b0, 0, 0, 0, 0, 24'hFFFFFF);
                reset = 1'b1;
                tick();
                reset = 1'b0;
                sample(sel, wr, a, wd, fd, rdy);
                chk("abort_wr", {28'd0, wr}, 0);
                chk("abort_done", {31'd0, fd}, 0);
                chk("abort_addr", {16'd0, a}, 0);
                tick();
                sample(sel, wr, a, wd, fd, rdy);
                chk("abort_no_done_later", {31'd0, fd}, 0);
                chk("abort_ready", {31'd0, rdy}, 1);
                done_cyc = 0;
                break;
            end
            tick();
        end
        if (done_cyc < 0) chk("fill_timeout", {31'd0, fd}, 1);
        span = done_cyc - first_wr;
    endtask

    int nwr, span;
    logic [15:0] fa, la;

    initial begin
        reset = 1'b1;
        d1_done = 1'b0;
        d2_done = 1'b0;
        drive_cmd(1, 1'b1, 1, 1, 1, 1, 24'h010203);
        drive_cmd(2, 1'b1, 1, 1, 1, 1, 24'h010203);
        tick();
        tick();
        chk("rst_wr", {28'd0, d1_wr}, 0);
        chk("rst_done", {31'd0, d1_fd}, 0);
        chk("rst_addr", {16'd0, d1_addr}, 0);
        chk("rst_wdat", d1_wdat, 0);
        chk("rst_rd", {31'd0, d1_rd}, 0);
        chk("rst_wr2", {28'd0, d2_wr}, 0);

        reset = 1'b0;
        drive_cmd(1, 1'b0, 0, 0, 0, 0, 24'h0);
        drive_cmd(2, 1'b0, 0, 0, 0, 0, 24'h0);
        tick();
        chk("cmd_in_reset_ignored", {28'd0, d1_wr}, 0);
        chk("ready_after_reset", {31'd0, c1_ready}, 1);

        d1_done = 1'b1;
        tick();
        d1_done = 1'b0;
        chk("idle_ack_wr", {28'd0, d1_wr}, 0);
        chk("idle_ack_done", {31'd0, d1_fd}, 0);
        chk("idle_ack_ready", {31'd0, c1_ready}, 1);

        run_fill(1, 3, 3, 5, 5, 24'h112233, -1, 0, nwr, span, fa, la);
        chk("single_nwr", nwr, 1);
        chk("single_addr", {16'd0, fa}, 32'h0194);

        run_fill(1, 7, 2, 0, 0, 24'h445566, -1, 0, nwr, span, fa, la);
        chk("empty_nwr", nwr, 0);

        run_fill(1, 0, 31, 0, 31, 24'hA5A5A5, -1, 0, nwr, span, fa, la);
        chk("full_nwr", nwr, 1024);
        chk("full_cycles", span, 2048);
        chk("full_first", {16'd0, fa}, 32'h0000);
        chk("full_last", {16'd0, la}, 32'h0FFC);

        run_fill(1, 2, 5, 10, 12, 24'h0F1E2D, 5, 0, nwr, span, fa, la);
        chk("stall_nwr", nwr, 12);
        chk("stall_first", {16'd0, fa}, 32'h0128);
        chk("stall_last", {16'd0, la}, 32'h02B0);

        run_fill(1, 0, 7, 0, 7, 24'h778899, -1, 5, nwr, span, fa, la);
        chk("abort_nwr", nwr, 5);

        run_fill(1, 10, 10, 20, 20, 24'hABCDEF, -1, 0, nwr, span, fa, la);
        chk("post_abort_nwr", nwr, 1);
        chk("post_abort_addr", {16'd0, fa}, 32'h0550);

        run_fill(2, 63, 63, 30, 31, 24'h010101, -1, 0, nwr, span, fa, la);
        chk("size2_nwr", nwr, 2);
        chk("size2_first", {16'd0, fa}, 32'h1FF8);
        chk("size2_last", {16'd0, la}, 32'h1FFC);
        chk("size2_rd", {31'd0, d2_rd}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/panel_fill.md
PANEL_FILL -- requirements
Module: panel_fill

Interface
REQ-001 Parameter: SIZE, default 1; number of chained 32-column panel segments; power of two, 1..16; XW = 5 + $clog2(SIZE).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  fill command present.
REQ-005 cmd_ready  output  1  high when the block can accept a command.
REQ-006 cmd_x0, cmd_x1  input  XW each  inclusive column bounds.
REQ-007 cmd_y0, cmd_y1  input  5 each  inclusive row bounds (0..31).
REQ-008 cmd_rgb  input  24  fill colour {r[7:0], g[7:0], b[7:0]}.
REQ-009 fill_done  output  1  one-cycle pulse when a command completes.
REQ-010 ctrl_wr  output  4  byte write strobes to the frame-buffer bus.
REQ-011 ctrl_rd  output  1  read strobe, tied 0.
REQ-012 ctrl_addr  output  16  byte address.
REQ-013 ctrl_wdat  output  32  write data.
REQ-014 ctrl_done  input  1  bus acknowledge from the panel driver.

Function
REQ-015 The FSM SHALL have states IDLE, WRITE and FINISH; cmd_ready = (state == IDLE).
REQ-016 In IDLE, cmd_valid && cmd_ready SHALL latch x0, x1, y0, y1 and rgb, and load cur_x = x0, cur_y = y0.
REQ-017 On acceptance with x0 > x1 or y0 > y1, the block SHALL go to FINISH and issue no bus write.
REQ-018 On acceptance with a non-empty rectangle, the block SHALL go to WRITE; ctrl_wr SHALL be asserted in the cycle after acceptance.
REQ-019 In WRITE, outputs SHALL be: ctrl_wr = 4'b0111; ctrl_addr = zero-extended {cur_x, cur_y, 2'b00}; ctrl_wdat = {8'h00, rgb}.
REQ-020 ctrl_wr, ctrl_addr and ctrl_wdat SHALL be held stable until a cycle in which ctrl_done = 1 is sampled.
REQ-021 On a sampled ctrl_done in WRITE, the block SHALL advance the scan order: y inner, x outer. If cur_y < y1 then cur_y+1; otherwise cur_y = y0 and cur_x+1.
REQ-022 When the acknowledged pixel is (x1, y1), the block SHALL go to FINISH and drive ctrl_wr = 0 in the next cycle.
REQ-023 Otherwise, the next pixel's write SHALL be presented in the cycle immediately after the acknowledge; no idle cycle is inserted.
REQ-024 With the standard driver (ctrl_done toggles), each pixel therefore costs 2 cycles.
REQ-025 FINISH SHALL last exactly one cycle, with fill_done = 1 and ctrl_wr = 0, then return to IDLE.
REQ-026 The earliest next acceptance SHALL be the cycle after FINISH.
REQ-027 Counters SHALL never wrap: the termination test uses equality with x1 and y1, evaluated before any increment.
REQ-028 When the rectangle covers all of column 32*SIZE-1 or row 31, the counters SHALL not overflow.
REQ-029 ctrl_done while not in WRITE SHALL be ignored.
REQ-030 cmd_* changes while the block is not in IDLE SHALL have no effect.
REQ-031 ctrl_rd SHALL be constant 0; ctrl_wr[3] SHALL be constant 0.
REQ-032 Pixel count per command = (x1-x0+1)*(y1-y0+1): exactly that many acknowledged writes, each address written once.

Reset
REQ-033 With reset = 1 at a clock edge, the next state SHALL be IDLE.
REQ-034 During and after reset: ctrl_wr = 0, fill_done = 0, ctrl_addr = 0, ctrl_wdat = 0, cur_x = cur_y = 0, and cmd_ready = 1 once reset deasserts.
REQ-035 Reset during WRITE SHALL abort the fill; ctrl_wr SHALL be 0 in the cycle after the reset edge, and no fill_done SHALL be generated.
REQ-036 A command presented in the same cycle as reset SHALL not be accepted.

Verification
REQ-037 Single pixel: SIZE=1, cmd x0=x1=3, y0=y1=5, rgb=24'h112233 -> one write, ctrl_addr=16'h0194, ctrl_wdat=32'h00112233, ctrl_wr=4'b0111; fill_done exactly once, 1 cycle after the acknowledge.
REQ-038 Full panel: SIZE=1, x 0..31, y 0..31 -> 1024 writes, addresses 0x000..0xFFC ascending by 4; no gaps or repeats; 2048 cycles from first ctrl_wr to FINISH with a toggling-ack model.
REQ-039 Empty command: x0=7, x1=2 -> zero writes; fill_done 1 cycle after acceptance; cmd_ready high again the following cycle.
REQ-040 Stalled ack: model delays ctrl_done by 0..5 random cycles on a 4x3 rectangle -> ctrl_addr/ctrl_wdat stable while ctrl_wr is high; 12 writes in y-inner order.
REQ-041 Reset mid-fill: assert reset after 5 acknowledges of an 8x8 fill -> ctrl_wr=0 the next cycle, no fill_done; a new 1x1 command afterwards completes normally.
REQ-042 SIZE=2 edge: x0=x1=63, y0=30, y1=31 -> addresses 0x1FF8 and 0x1FFC; no counter overflow; cmd_valid toggling during the fill is ignored.
